// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer: frames an SPI bit stream into a command, a base address and a burst of data words.
// It raises write strobes and read-prefetch requests with auto-incremented addresses and shifts read data out on spi_cipo.
`default_nettype none

module spi_burst_sequencer #(
    parameter int ASZ  = 7,
    parameter int DSZ  = 32,
    parameter int MAXW = 16
) (
    input  logic                        spi_clk,
    input  logic                        spi_reset,
    input  logic                        spi_copi,
    output logic                        spi_cipo,
    input  logic [DSZ-1:0]              rdat,
    output logic                        rd_req,
    output logic [ASZ-1:0]              rd_addr,
    output logic                        wr_stb,
    output logic [ASZ-1:0]              wr_addr,
    output logic [DSZ-1:0]              wr_data,
    output logic [$clog2(MAXW+1)-1:0]   word_cnt,
    output logic                        burst_ovf
);
    localparam int WCW = $clog2(MAXW + 1);
    localparam int BCW = $clog2((DSZ > ASZ) ? DSZ : ASZ);

    typedef enum logic [1:0] {
        S_CMD  = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [BCW-1:0] bit_cnt;
    logic [BCW-1:0] bit_cnt_nxt;
    logic           rd_flag;
    logic [DSZ-2:0] shift_in;
    logic [DSZ-1:0] shift_nxt;
    logic [ASZ-1:0] cur_addr;
    logic [DSZ-1:0] shift_out;
    logic           hdr_done;
    logic           word_done;
    logic           last_word;

    assign shift_nxt = {shift_in, spi_copi};
    assign last_word = (word_cnt == WCW'(MAXW - 1));

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt + 1'b1;
        hdr_done    = 1'b0;
        word_done   = 1'b0;
        case (state)
            S_CMD: begin
                state_nxt   = S_ADDR;
                bit_cnt_nxt = '0;
            end
            S_ADDR: begin
                if (bit_cnt == BCW'(ASZ - 1)) begin
                    hdr_done    = 1'b1;
                    state_nxt   = S_DATA;
                    bit_cnt_nxt = '0;
                end
            end
            S_DATA: begin
                if (bit_cnt == BCW'(DSZ - 1)) begin
                    word_done   = 1'b1;
                    bit_cnt_nxt = '0;
                    if (last_word) begin
                        state_nxt = S_HALT;
                    end
                end
            end
            default: begin
                bit_cnt_nxt = bit_cnt;
            end
        endcase
    end

    always_ff @(posedge spi_clk or posedge spi_reset) begin
        if (spi_reset) begin
            state     <= S_CMD;
            bit_cnt   <= '0;
            rd_flag   <= 1'b0;
            shift_in  <= '0;
            cur_addr  <= '0;
            word_cnt  <= '0;
            burst_ovf <= 1'b0;
            rd_req    <= 1'b0;
            wr_stb    <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift_in <= shift_nxt[DSZ-2:0];
            if (state == S_CMD) begin
                rd_flag <= spi_copi;
            end
            if (hdr_done) begin
                cur_addr <= shift_nxt[ASZ-1:0];
            end
            if (word_done) begin
                cur_addr <= cur_addr + 1'b1;
                word_cnt <= word_cnt + 1'b1;
            end
            if (state == S_HALT) begin
                burst_ovf <= 1'b1;
            end
            // No prefetch after the final word: nothing would ever shift it out.
            rd_req <= rd_flag && (hdr_done || (word_done && !last_word));
            wr_stb <= !rd_flag && word_done;
        end
    end

    // Unreset so downstream synchronisers can still sample them after cs rises.
    always_ff @(posedge spi_clk) begin
        if (hdr_done && rd_flag) begin
            rd_addr <= shift_nxt[ASZ-1:0];
        end
        if (word_done && rd_flag && !last_word) begin
            rd_addr <= cur_addr + 1'b1;
        end
        if (word_done && !rd_flag) begin
            wr_addr <= cur_addr;
            wr_data <= shift_nxt;
        end
    end

    always_ff @(negedge spi_clk or posedge spi_reset) begin
        if (spi_reset) begin
            shift_out <= '0;
        end else if (rd_req) begin
            shift_out <= rdat;
        end else begin
            shift_out <= {shift_out[DSZ-2:0], 1'b0};
        end
    end

    assign spi_cipo = (state == S_DATA) && rd_flag && shift_out[DSZ-1];

endmodule

`default_nettype wire

// File: tb/tb_spi_burst_sequencer.sv
// Bench for spi_burst_sequencer: directed and random transfers, compared every cycle against a bit-position model.
`default_nettype none

module tb_spi_burst_sequencer;
    localparam int ASZ  = 7;
    localparam int DSZ  = 32;
    localparam int MAXW = 4;
    localparam int WCW  = $clog2(MAXW + 1);
    localparam int H    = 1 + ASZ;
    localparam int L    = H + MAXW * DSZ;

    logic            spi_clk   = 1'b0;
    logic            spi_reset = 1'b1;
    logic            spi_copi  = 1'b0;
    logic            spi_cipo;
    logic [DSZ-1:0]  rdat;
    logic            rd_req;
    logic [ASZ-1:0]  rd_addr;
    logic            wr_stb;
    logic [ASZ-1:0]  wr_addr;
    logic [DSZ-1:0]  wr_data;
    logic [WCW-1:0]  word_cnt;
    logic            burst_ovf;

    spi_burst_sequencer #(.ASZ(ASZ), .DSZ(DSZ), .MAXW(MAXW)) dut (
        .spi_clk   (spi_clk),
        .spi_reset (spi_reset),
        .spi_copi  (spi_copi),
        .spi_cipo  (spi_cipo),
        .rdat      (rdat),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .word_cnt  (word_cnt),
        .burst_ovf (burst_ovf)
    );

    // Register bank: every address reads as 0xA5A50000 + addr.
    assign rdat = 32'hA5A50000 + {25'd0, rd_addr};

    always #5 spi_clk = ~spi_clk;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    always @(posedge spi_clk or posedge spi_reset) begin
        if (spi_reset) edges <= 0;
        else           edges <= edges + 1;
    end

    bit              m_rd = 1'b0;
    logic [ASZ-1:0]  m_base = '0;
    logic [DSZ-1:0]  m_words [0:MAXW+1];
    bit              have_w = 1'b0;
    logic [ASZ-1:0]  exp_wa;
    logic [DSZ-1:0]  exp_wd;
    int              stb_seen, req_seen;
    bit              mon_on = 1'b0;
    logic            bits [0:255];
    logic [63:0]     cap;
    logic            end_ovf;
    int              end_wcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DSZ-1:0] rmodel(input logic [ASZ-1:0] a);
        return {16'hA5A5, 9'd0, a};
    endfunction

    // Expected outputs after n rising edges of the current transfer.
    task automatic check_regs();
        int n, k, wc;
        bit e_ws, e_rr;
        logic [ASZ-1:0] e_ra;
        n = edges; e_ws = 0; e_rr = 0; e_ra = '0;
        if (!m_rd && n > H && n <= L && (n - H) % DSZ == 0) begin
            e_ws = 1; k = (n - H) / DSZ - 1;
            have_w = 1; exp_wa = ASZ'(m_base + k); exp_wd = m_words[k];
        end
        if (m_rd && (n == H || (n > H && n < L && (n - H) % DSZ == 0))) begin
            e_rr = 1; e_ra = ASZ'(m_base + (n - H) / DSZ);
        end
        wc = (n <= H) ? 0 : (((n - H) / DSZ > MAXW) ? MAXW : (n - H) / DSZ);
        chk("wr_stb", wr_stb, e_ws);
        chk("rd_req", rd_req, e_rr);
        chk("word_cnt", word_cnt, wc);
        chk("burst_ovf", burst_ovf, n > L);
        if (e_rr) chk("rd_addr", rd_addr, e_ra);
        if (have_w) begin
            chk("wr_addr", wr_addr, exp_wa);
            chk("wr_data", wr_data, exp_wd);
        end
        if (wr_stb) stb_seen++;
        if (rd_req) req_seen++;
    endtask

    // Expected cipo for the upcoming rising edge (0-based index n).
    task automatic check_cipo();
        int n;
        bit e;
        logic [DSZ-1:0] w;
        n = edges; e = 0;
        if (m_rd && n >= H && n < L) begin
            w = rmodel(ASZ'(m_base + (n - H) / DSZ));
            e = w[DSZ - 1 - ((n - H) % DSZ)];
        end
        chk("spi_cipo", spi_cipo, e);
    endtask

    initial begin : compare
        forever begin
            @(posedge spi_clk); #1;
            if (mon_on) check_regs();
            @(negedge spi_clk); #1;
            if (mon_on) check_cipo();
        end
    end

    task automatic xfer(input bit rd, input logic [ASZ-1:0] base, input int nw,
                        input int extra, input int cut);
        int p;
        p = 0;
        bits[p] = rd; p = p + 1;
        for (int i = ASZ - 1; i >= 0; i--) begin bits[p] = base[i]; p = p + 1; end
        for (int w = 0; w < nw; w++)
            for (int i = DSZ - 1; i >= 0; i--) begin bits[p] = m_words[w][i]; p = p + 1; end
        for (int i = 0; i < extra; i++) begin bits[p] = 1'($urandom); p = p + 1; end
        if (cut > 0 && cut < p) p = cut;
        @(negedge spi_clk);
        m_rd = rd; m_base = base; stb_seen = 0; req_seen = 0;
        spi_reset = 1'b0;
        for (int i = 0; i < p; i++) begin
            spi_copi = bits[i];
            #1;
            if (i >= H && i - H < 64) cap[63 - (i - H)] = spi_cipo;
            @(negedge spi_clk);
        end
        end_ovf = burst_ovf; end_wcnt = word_cnt;
        #3; spi_reset = 1'b1; spi_copi = 1'b0;
        #1;
        chk("rst_rd_req", rd_req, 0);
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_cipo", spi_cipo, 0);
        chk("rst_ovf", burst_ovf, 0);
        @(negedge spi_clk); @(negedge spi_clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        int nw, cut;
        repeat (2) @(negedge spi_clk);
        chk("init_rd_req", rd_req, 0);
        chk("init_wr_stb", wr_stb, 0);
        chk("init_word_cnt", word_cnt, 0);
        chk("init_ovf", burst_ovf, 0);
        chk("init_cipo", spi_cipo, 0);
        mon_on = 1'b1;

        m_words[0] = 32'hDEADBEEF;
        xfer(0, 7'h05, 1, 0, 0);
        chk("w1_stb_count", stb_seen, 1);
        chk("w1_req_count", req_seen, 0);
        chk("w1_wr_addr", wr_addr, 7'h05);
        chk("w1_wr_data", wr_data, 32'hDEADBEEF);
        chk("w1_word_cnt", end_wcnt, 1);

        m_words[0] = 32'h11111111; m_words[1] = 32'h22222222; m_words[2] = 32'h33333333;
        xfer(0, 7'h7E, 3, 0, 0);
        chk("wrap_stb_count", stb_seen, 3);
        chk("wrap_wr_addr", wr_addr, 7'h00);
        chk("wrap_wr_data", wr_data, 32'h33333333);

        xfer(1, 7'h10, 2, 0, 0);
        chk("rd2_cipo_words", cap, 64'hA5A50010_A5A50011);
        chk("rd2_req_count", req_seen, 3);
        chk("rd2_stb_count", stb_seen, 0);

        m_words[0] = $urandom;
        xfer(0, 7'h20, 1, 0, H + 12);
        chk("rstmid_stb_count", stb_seen, 0);
        chk("rstmid_word_cnt", end_wcnt, 0);
        chk("rstmid_wr_addr_held", wr_addr, 7'h00);

        for (int i = 0; i < MAXW + 1; i++) m_words[i] = 32'h01010101 * (i + 1);
        xfer(0, 7'h00, MAXW + 1, 0, 0);
        chk("ovf_stb_count", stb_seen, MAXW);
        chk("ovf_flag", end_ovf, 1);
        chk("ovf_wr_addr", wr_addr, MAXW - 1);

        xfer(1, 7'h7E, MAXW, 5, 0);
        chk("rdhalt_cipo_words", cap, 64'hA5A5007E_A5A5007F);
        chk("rdhalt_req_count", req_seen, MAXW);
        chk("rdhalt_ovf", end_ovf, 1);

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < MAXW + 2; i++) m_words[i] = $urandom;
            nw  = $urandom_range(1, MAXW + 1);
            cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, H + nw * DSZ) : 0;
            xfer(1'($urandom), 7'($urandom), nw, $urandom_range(0, 3), cut);
        end

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_burst_sequencer.md
# spi_burst_sequencer

SPI-clock-domain framing stage for multi-word register transfers. It decodes the raw SPI bit stream into a read/write flag, a base address and a run of data words, auto-incrementing the address per word. It emits per-word write strobes and read-prefetch requests to the register-bank side, and returns read data on spi_cipo. Downstream system-clock synchronisers consume its strobes and held data/address.

## Interface
- ASZ, 7, address width
- DSZ, 32, data word width
- MAXW, 16, maximum words per transfer (≥1)

- spi_clk  in  1  SPI clock, CPOL=0; copi sampled on rising edge, cipo driven on falling edge
- spi_reset  in  1  reset, asynchronous, active-high (system reset OR'd with spi_cs)
- spi_copi  in  1  serial data in, MSB first
- spi_cipo  out  1  serial data out
- rdat  in  DSZ  read data for rd_addr; valid within half an spi_clk period of rd_req rising
- rd_req  out  1  read-prefetch pulse, one spi_clk cycle
- rd_addr  out  ASZ  address for rd_req
- wr_stb  out  1  write pulse, one spi_clk cycle
- wr_addr  out  ASZ  address of completed write word
- wr_data  out  DSZ  completed write word
- word_cnt  out  $clog2(MAXW+1)  completed words in current transfer
- burst_ovf  out  1  sticky: host clocked bits past MAXW words

## Operation
- States: CMD → ADDR → DATA (repeats per word) → HALT.
- CMD: 1 bit; captures rd flag (1 = read, 0 = write) → ADDR.
- ADDR: ASZ bits MSB first; base address captured on last bit → DATA. Read transfer: rd_req=1, rd_addr=base on the same edge.
- DATA: bit counter 0..DSZ-1. On bit DSZ-1 edge: word k (k from 0) completes; word_cnt+1.
  - Write: wr_data={shift[DSZ-2:0],copi}, wr_addr=(base+k) mod 2^ASZ, wr_stb=1.
  - Read: if k+1<MAXW, rd_req=1, rd_addr=(base+k+1) mod 2^ASZ.
  - If k+1==MAXW → HALT; else stay in DATA, bit counter → 0.
- HALT: any further rising edge sets burst_ovf; no strobes/requests; cipo 0.
- Address arithmetic: ASZ-bit modulo; 0x7F+1 → 0x00.
- Outgoing shift register (falling edge): load rdat when rd_req high, else shift left with 0 fill. spi_cipo = shift MSB in read DATA state, else 0.
- Write transfers never raise rd_req; read transfers never raise wr_stb.
- Reset (spi_reset high, async): state CMD, counters 0, rd_req=0, wr_stb=0, word_cnt=0, burst_ovf=0, spi_cipo=0, outgoing shift register 0. wr_data, wr_addr, rd_addr are not reset (hold last values across cs rise for downstream sampling); 0 at power-on in simulation.
- Reset mid-word: partial word discarded, no wr_stb, word_cnt keeps only completed words until reset clears it.

## Timing
- All state on spi_clk rising edge except outgoing shift register (falling edge).
- rd_req, wr_stb: high from the completing rising edge to the next rising edge; cleared immediately by spi_reset.
- Read latency: rdat loaded on the falling edge after rd_req rises; its MSB is sampled by the host on the next rising edge, i.e. zero bubble between header and first read word and between consecutive words.
- Header = 1+ASZ bits; each word = DSZ bits; transfer of n words = 1+ASZ+n·DSZ clocks.
- wr_data/wr_addr update on the same edge as wr_stb and hold until the next completed write word.

## Test plan
- Write 1 word: flag 0, addr 0x05, data 0xDEADBEEF → one wr_stb, wr_addr=0x05, wr_data=0xDEADBEEF, word_cnt=1, rd_req never high.
- Write burst wrap: addr 0x7E, words 0x11111111, 0x22222222, 0x33333333 → wr_stb ×3 with wr_addr 0x7E, 0x7F, 0x00 and matching data.
- Read 2 words: addr 0x10, model returns rdat=0xA5A50000+addr → rd_req at header end (0x10) and after word 0 (0x11); cipo shifts 0xA5A50010 then 0xA5A50011 MSB first.
- Reset mid-word: write header addr 0x20, 12 data bits, spi_reset high → no wr_stb, word_cnt=0, cipo=0; next full transfer works normally.
- Overflow, MAXW=2: write 3 words at addr 0x00 → wr_stb only for 0x00, 0x01; burst_ovf=1 after first extra bit, held until spi_reset.
- Read in HALT, MAXW=1: read at 0x03 → one rd_req, 32 data bits of rdat on cipo, then cipo=0 and burst_ovf=1 on further clocks.
